// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter: grant/load one cycle after Req in IDLE.
// Holds the latched byte until TxDone or watchdog expiry; requesters wait (level Req) while busy.
module uart_tx_arbiter #(
    parameter int NumReq        = 4,
    parameter int IdWidth       = 2,
    parameter int TimeoutCycles = 25000,
    parameter int TimeoutWidth  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NumReq-1:0]     Req,
    input  logic [8*NumReq-1:0]   ReqData,
    output logic [NumReq-1:0]     Grant,
    output logic                  TxDataLoad,
    output logic [7:0]            TxDataIn,
    input  logic                  TxDone,
    output logic                  Busy,
    output logic [IdWidth-1:0]    ActiveId,
    output logic                  Timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NumReq-1:0]       grant_q, grant_d;
    logic                    load_q, load_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    busy_q, busy_d;
    logic [IdWidth-1:0]      active_id_q, active_id_d;
    logic                    timeout_q, timeout_d;
    logic [IdWidth-1:0]      ptr_q, ptr_d;
    logic [TimeoutWidth-1:0] wdog_q, wdog_d;

    logic                    sel_vld;
    logic [IdWidth-1:0]      sel;
    logic [IdWidth-1:0]      idx;

    // Scan from the highest offset down so the nearest set bit at or above ptr_q wins.
    always_comb begin
        sel_vld = 1'b0;
        sel     = ptr_q;
        idx     = ptr_q;
        for (int i = NumReq - 1; i >= 0; i--) begin
            idx = ptr_q + IdWidth'(i);
            if (Req[idx]) begin
                sel_vld = 1'b1;
                sel     = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = '0;
        load_d      = 1'b0;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        active_id_d = active_id_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        wdog_d      = wdog_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    grant_d[sel] = 1'b1;
                    load_d       = 1'b1;
                    tx_data_d    = ReqData[{sel, 3'b000} +: 8];
                    active_id_d  = sel;
                    busy_d       = 1'b1;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wdog_d  = '0;
                ptr_d   = active_id_q + IdWidth'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wdog_d = wdog_q + TimeoutWidth'(1);
                // TxDone takes precedence over a coincident terminal count.
                if (TxDone) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (wdog_q == TimeoutWidth'(TimeoutCycles - 1)) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            load_q      <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            active_id_q <= '0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            load_q      <= load_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            active_id_q <= active_id_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            wdog_q      <= wdog_d;
        end
    end

    assign Grant      = grant_q;
    assign TxDataLoad = load_q;
    assign TxDataIn   = tx_data_q;
    assign Busy       = busy_q;
    assign ActiveId   = active_id_q;
    assign Timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table on the default instance plus
// hand sequences for spacing, watchdog (short-timeout instance) and mid-frame reset.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_t;
    logic [31:0] req_data, req_data_t;
    logic        tx_done, tx_done_t;
    logic [3:0]  grant, grant_t;
    logic        load, load_t;
    logic [7:0]  txd, txd_t;
    logic        busy, busy_t;
    logic [1:0]  aid, aid_t;
    logic        to, to_t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter dut (
        .Clock(clk), .Reset(rst), .Req(req), .ReqData(req_data),
        .Grant(grant), .TxDataLoad(load), .TxDataIn(txd), .TxDone(tx_done),
        .Busy(busy), .ActiveId(aid), .Timeout(to)
    );

    uart_tx_arbiter #(.NumReq(4), .IdWidth(2), .TimeoutCycles(50), .TimeoutWidth(16)) dut_wd (
        .Clock(clk), .Reset(rst), .Req(req_t), .ReqData(req_data_t),
        .Grant(grant_t), .TxDataLoad(load_t), .TxDataIn(txd_t), .TxDone(tx_done_t),
        .Busy(busy_t), .ActiveId(aid_t), .Timeout(to_t)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic        done;
        logic [3:0]  grant;
        logic        load;
        logic [7:0]  txd;
        logic        busy;
        logic [1:0]  aid;
        logic        to;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0; req_data = '0; tx_done = 1'b0;
        req_t = '0; req_data_t = '0; tx_done_t = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0]  exp_g;
        logic        ok;
        logic        found;
        int          last_l;

        vecs[0]  = '{4'b0001, 32'h000000AA, 1'b0, 4'b0001, 1'b1, 8'hAA, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{4'b0000, 32'h000000AA, 1'b0, 4'b0000, 1'b0, 8'hAA, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{4'b0000, 32'h000000AA, 1'b0, 4'b0000, 1'b0, 8'hAA, 1'b1, 2'd0, 1'b0};
        vecs[3]  = '{4'b0000, 32'h000000AA, 1'b1, 4'b0000, 1'b0, 8'hAA, 1'b0, 2'd0, 1'b0};
        vecs[4]  = '{4'b0000, 32'h000000AA, 1'b0, 4'b0000, 1'b0, 8'hAA, 1'b0, 2'd0, 1'b0};
        vecs[5]  = '{4'b0101, 32'h00220011, 1'b0, 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2, 1'b0};
        vecs[6]  = '{4'b0001, 32'h00220011, 1'b1, 4'b0000, 1'b0, 8'h22, 1'b1, 2'd2, 1'b0};
        vecs[7]  = '{4'b0001, 32'h00220011, 1'b0, 4'b0000, 1'b0, 8'h22, 1'b1, 2'd2, 1'b0};
        vecs[8]  = '{4'b0001, 32'h00220011, 1'b1, 4'b0000, 1'b0, 8'h22, 1'b0, 2'd2, 1'b0};
        vecs[9]  = '{4'b0101, 32'h00220033, 1'b0, 4'b0001, 1'b1, 8'h33, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{4'b0100, 32'h00220033, 1'b0, 4'b0000, 1'b0, 8'h33, 1'b1, 2'd0, 1'b0};
        vecs[11] = '{4'b0100, 32'h00220033, 1'b1, 4'b0000, 1'b0, 8'h33, 1'b0, 2'd0, 1'b0};
        vecs[12] = '{4'b0100, 32'h00220033, 1'b0, 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2, 1'b0};
        vecs[13] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h22, 1'b1, 2'd2, 1'b0};
        vecs[14] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h22, 1'b0, 2'd2, 1'b0};
        vecs[15] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h22, 1'b0, 2'd2, 1'b0};

        // Reset values
        do_reset;
        chk("reset_outputs", {15'd0, grant, load, txd, busy, aid, to}, 32'd0);
        chk("reset_outputs_wd", {15'd0, grant_t, load_t, txd_t, busy_t, aid_t, to_t}, 32'd0);

        // Cycle table: basic frame, TxDone in LOAD ignored, wrap from Ptr=3
        for (int i = 0; i < 16; i++) begin
            req = vecs[i].req; req_data = vecs[i].data; tx_done = vecs[i].done;
            step;
            chk($sformatf("vec%0d", i), {15'd0, grant, load, txd, busy, aid, to},
                {15'd0, vecs[i].grant, vecs[i].load, vecs[i].txd, vecs[i].busy, vecs[i].aid, vecs[i].to});
        end
        tx_done = 1'b0;

        // All four requesting, TxDone 100 cycles after each load
        do_reset;
        req = 4'b1111; req_data = 32'h44332211;
        last_l = 0;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int c = 0; c < 300; c++) begin
                step;
                if (load === 1'b1) begin
                    found = 1'b1;
                    break;
                end
            end
            chk($sformatf("rr_load_seen%0d", k), {31'd0, found}, 32'd1);
            exp_g = 4'b0001 << k;
            chk($sformatf("rr_grant%0d", k), {28'd0, grant}, {28'd0, exp_g});
            if (k > 0) chk($sformatf("rr_spacing%0d", k), cyc - last_l, 32'd102);
            last_l = cyc;
            req[k] = 1'b0;
            repeat (100) step;
            tx_done = 1'b1;
            step;
            tx_done = 1'b0;
            chk($sformatf("rr_idle%0d", k), {31'd0, busy}, 32'd0);
        end

        // Watchdog expiry on the 50-cycle instance, with requester 3 queued
        req_t = 4'b0010; req_data_t = 32'h00007E00;
        step;
        chk("wd_grant", {19'd0, grant_t, load_t, txd_t}, {19'd0, 4'b0010, 1'b1, 8'h7E});
        req_t = 4'b1000; req_data_t = 32'h99007E00;
        step;
        chk("wd_enter_wait", {30'd0, busy_t, load_t}, {30'd0, 1'b1, 1'b0});
        ok = 1'b1;
        for (int i = 1; i < 50; i++) begin
            step;
            if (to_t !== 1'b0 || busy_t !== 1'b1) ok = 1'b0;
        end
        chk("wd_quiet_49", {31'd0, ok}, 32'd1);
        step;
        chk("wd_timeout_pulse", {30'd0, to_t, busy_t}, {30'd0, 1'b1, 1'b0});
        step;
        chk("wd_next_grant", {17'd0, to_t, grant_t, aid_t, txd_t}, {17'd0, 1'b0, 4'b1000, 2'd3, 8'h99});
        req_t = 4'b0000;
        step;
        tx_done_t = 1'b1;
        step;
        tx_done_t = 1'b0;
        chk("wd_done_idle", {30'd0, busy_t, to_t}, 32'd0);

        // TxDone coincident with terminal count
        req_t = 4'b0001; req_data_t = 32'h00000055;
        step;
        chk("coin_grant", {28'd0, grant_t}, 32'd1);
        req_t = 4'b0000;
        step;
        repeat (49) step;
        tx_done_t = 1'b1;
        step;
        tx_done_t = 1'b0;
        chk("coin_no_timeout", {30'd0, to_t, busy_t}, 32'd0);
        step;
        chk("coin_still_quiet", {31'd0, to_t}, 32'd0);

        // Reset in WAIT with TxDataIn=5C
        req = 4'b0100; req_data = 32'h005C0000;
        step;
        chk("rst_mid_grant", {28'd0, grant}, 32'b0100);
        req = 4'b0000;
        step;
        step;
        chk("rst_mid_hold", {23'd0, txd, busy}, {23'd0, 8'h5C, 1'b1});
        rst = 1'b1;
        step;
        chk("rst_mid_outputs", {15'd0, grant, load, txd, busy, aid, to}, 32'd0);
        rst = 1'b0;
        req = 4'b1111; req_data = 32'h44332211;
        step;
        chk("rst_ptr_zero", {19'd0, grant, load, txd}, {19'd0, 4'b0001, 1'b1, 8'h11});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
